// File: rtl/cache_cmd_exec.sv
// Cache maintenance walker: invalidate / writeback / writeback+invalidate of all lines.
// Optional writeback statistics counter enabled by macro CACHE_CMD_STAT_EN.
module cache_cmd_exec #(
   parameter int INDEX_WIDTH = 6,
   parameter int LINE_NUM    = 64
) (
   input  logic                   clk,
   input  logic                   rest,
   input  logic [1:0]             cmd,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   output logic                   busy,
   output logic [INDEX_WIDTH-1:0] line_index,
   output logic                   line_rd,
   input  logic                   line_dirty,
   output logic                   line_wb,
   input  logic                   line_wb_done,
   output logic                   line_inv
`ifdef CACHE_CMD_STAT_EN
   ,
   output logic [15:0]            wb_count
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CHECK,
      WB,
      INV,
      NEXT,
      DONE
   } state_t;

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LINE_NUM - 1);

   state_t                   state;
   state_t                   state_nxt;
   logic [1:0]               cmd_q;
   logic                     accept;
   logic                     last;

   assign accept = (state == IDLE) && cmd_valid;
   assign last   = (line_index == LAST_IDX);

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The command is captured once; the walk never looks at cmd again.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         cmd_q      <= 2'b00;
         line_index <= '0;
      end else if (accept) begin
         cmd_q      <= cmd;
         line_index <= '0;
      end else if (state == NEXT && !last) begin
         line_index <= line_index + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt = (cmd == 2'b00) ? DONE : READ;
            end
         end
         READ: state_nxt = CHECK;
         CHECK: begin
            if (cmd_q[1] && line_dirty) begin
               state_nxt = WB;
            end else if (cmd_q[0]) begin
               state_nxt = INV;
            end else begin
               state_nxt = NEXT;
            end
         end
         WB: begin
            if (line_wb_done) begin
               state_nxt = cmd_q[0] ? INV : NEXT;
            end
         end
         INV:  state_nxt = NEXT;
         NEXT: state_nxt = last ? DONE : READ;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign line_rd   = (state == READ);
   assign line_wb   = (state == WB);
   assign line_inv  = (state == INV);
   assign cmd_ready = (state == DONE);

`ifdef CACHE_CMD_STAT_EN
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         wb_count <= '0;
      end else if (accept) begin
         wb_count <= '0;
      end else if (line_wb && line_wb_done && wb_count != 16'hFFFF) begin
         wb_count <= wb_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_cmd_exec.sv
// Randomized bench for cache_cmd_exec against an event-sequence reference model.
// Also covers reset mid-writeback and stray writeback-done pulses.
module tb_cache_cmd_exec;

   localparam int IW = 2;
   localparam int LN = 4;
   localparam int LIMIT = 2000;

   logic          clk = 1'b0;
   logic          rest = 1'b1;
   logic [1:0]    cmd = 2'b00;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          busy;
   logic [IW-1:0] line_index;
   logic          line_rd;
   logic          line_dirty = 1'b0;
   logic          line_wb;
   logic          line_wb_done = 1'b0;
   logic          line_inv;
`ifdef CACHE_CMD_STAT_EN
   logic [15:0]   wb_count;
`endif

   cache_cmd_exec #(
      .INDEX_WIDTH(IW),
      .LINE_NUM(LN)
   ) dut (
      .clk(clk),
      .rest(rest),
      .cmd(cmd),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .busy(busy),
      .line_index(line_index),
      .line_rd(line_rd),
      .line_dirty(line_dirty),
      .line_wb(line_wb),
      .line_wb_done(line_wb_done),
      .line_inv(line_inv)
`ifdef CACHE_CMD_STAT_EN
      ,
      .wb_count(wb_count)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Memory side: dirty flags and writeback latency of the current run
   logic [LN-1:0] dmask = '0;
   int            wb_dly = 0;
   bit            rd_seen = 0;
   int            rd_idx = 0;
   int            wb_cnt = 0;

   always @(negedge clk) begin
      line_dirty = rd_seen ? dmask[rd_idx] : 1'($urandom);
      rd_seen    = line_rd;
      rd_idx     = int'(line_index);
      if (line_wb) begin
         line_wb_done = (wb_cnt == wb_dly);
         wb_cnt++;
      end else begin
         wb_cnt       = 0;
         line_wb_done = ($urandom_range(3) == 0);
      end
   end

   // Observed activity: code = kind*16 + index (1 rd, 2 wb rise, 3 inv)
   int  ev_q[$];
   int  ready_cnt = 0;
   int  excl_err = 0;
   bit  wb_prev = 0;

   always @(negedge clk) begin
      if (line_rd)             ev_q.push_back(16 + int'(line_index));
      if (line_wb && !wb_prev) ev_q.push_back(32 + int'(line_index));
      if (line_inv)            ev_q.push_back(48 + int'(line_index));
      if (cmd_ready)           ready_cnt++;
      if (int'(line_rd) + int'(line_wb) + int'(line_inv) > 1) excl_err++;
      wb_prev = line_wb;
   end

   task automatic run_cmd(input logic [1:0] c, input logic [LN-1:0] dm,
                          input int dly);
      int exp_q[$];
      int exp_cyc;
      int n;
      int got;
      int nwb;
      dmask  = dm;
      wb_dly = dly;
      @(negedge clk);
      #1;
      ev_q.delete();
      ready_cnt = 0;
      excl_err  = 0;
      cmd       = c;
      cmd_valid = 1'b1;
      n   = 0;
      got = -1;
      while (got < 0 && n < LIMIT) begin
         @(negedge clk);
         #1;
         n++;
         if (cmd_ready) got = n;
         else if (busy) cmd = 2'($urandom);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      exp_cyc = 1;
      nwb = 0;
      if (c != 2'b00) begin
         for (int i = 0; i < LN; i++) begin
            exp_q.push_back(16 + i);
            exp_cyc += 3;
            if (c[1] && dm[i]) begin
               exp_q.push_back(32 + i);
               exp_cyc += dly + 1;
               nwb++;
            end
            if (c[0]) begin
               exp_q.push_back(48 + i);
               exp_cyc += 1;
            end
         end
      end
      check("ready_cycle", got, exp_cyc);
      check("ready_pulses", ready_cnt, 1);
      check("idle_after", int'(busy), 0);
      check("exclusive", excl_err, 0);
      check("seq_len", ev_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
         check("seq_event", ev_q[i], exp_q[i]);
`ifdef CACHE_CMD_STAT_EN
      check("wb_count", int'(wb_count), nwb);
`endif
   endtask

   task automatic check_quiet(input string tag);
      check(tag, int'({cmd_ready, busy, line_rd, line_wb, line_inv}), 0);
      check({tag, "_idx"}, int'(line_index), 0);
`ifdef CACHE_CMD_STAT_EN
      check({tag, "_wbc"}, int'(wb_count), 0);
`endif
   endtask

   initial begin
      int n;
      #12;
      check_quiet("reset_state");
      @(negedge clk);
      rest = 1'b0;

      run_cmd(2'b01, 4'b0000, 0);
      run_cmd(2'b10, 4'b1010, 3);
      run_cmd(2'b11, 4'b0100, 1);
      run_cmd(2'b00, 4'b1111, 2);
      run_cmd(2'b11, 4'b1111, 0);

      // Reset while writing back line 1
      dmask  = 4'b0010;
      wb_dly = 50;
      @(negedge clk);
      #1;
      ready_cnt = 0;
      cmd       = 2'b10;
      cmd_valid = 1'b1;
      n = 0;
      while (!(line_wb && line_index == IW'(1)) && n < LIMIT) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reach_wb", int'(line_wb), 1);
      #2;
      rest      = 1'b1;
      cmd_valid = 1'b0;
      #1;
      check_quiet("async_reset");
      repeat (2) @(negedge clk);
      rest = 1'b0;
      check("no_ready_on_reset", ready_cnt, 0);
      run_cmd(2'b01, 4'b1111, 0);

      for (int t = 0; t < 24; t++)
         run_cmd(2'($urandom), LN'($urandom), int'($urandom_range(3)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_cmd_exec.md
CACHE_CMD_EXEC -- requirements
Module: cache_cmd_exec

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 6: width of the cache line index.
REQ-002 SHALL have parameter LINE_NUM, default 64: number of lines walked; LINE_NUM <= 2**INDEX_WIDTH.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rest  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd  input  2: maintenance command; 00 NOP, 01 invalidate-all, 10 writeback-all, 11 writeback+invalidate-all.
REQ-006 SHALL have port cmd_valid  input  1: command request, held by the requester until cmd_ready.
REQ-007 SHALL have port cmd_ready  output  1: one-cycle completion/acknowledge pulse.
REQ-008 SHALL have port busy  output  1: high whenever the state is not IDLE.
REQ-009 SHALL have port line_index  output  INDEX_WIDTH: index of the line being operated on.
REQ-010 SHALL have port line_rd  output  1: tag/status read strobe for line_index.
REQ-011 SHALL have port line_dirty  input  1: dirty flag of line_index, valid the cycle after line_rd.
REQ-012 SHALL have port line_wb  output  1: writeback request for line_index, level-held.
REQ-013 SHALL have port line_wb_done  input  1: one-cycle pulse ending a writeback.
REQ-014 SHALL have port line_inv  output  1: one-cycle pulse clearing valid and dirty of line_index.

Function
REQ-015 SHALL implement FSM states IDLE, READ, CHECK, WB, INV, NEXT, DONE.
REQ-016 IDLE: on cmd_valid, SHALL latch cmd, set line_index=0, go to DONE if cmd=00, else to READ.
REQ-017 READ: SHALL assert line_rd for exactly one cycle, then go to CHECK.
REQ-018 CHECK: SHALL go to WB if cmd[1]=1 and line_dirty=1; else to INV if cmd[0]=1; else to NEXT.
REQ-019 WB: SHALL hold line_wb high until line_wb_done=1; on that cycle SHALL go to INV if cmd[0]=1, else to NEXT.
REQ-020 INV: SHALL assert line_inv for exactly one cycle, then go to NEXT.
REQ-021 NEXT: SHALL go to DONE if line_index==LINE_NUM-1; else increment line_index and go to READ.
REQ-022 DONE: SHALL assert cmd_ready for exactly one cycle, then go to IDLE.
REQ-023 Latency: if cmd_valid is sampled at edge 0 and all lines are clean, cmd_ready SHALL be high in cycle 4*LINE_NUM+1 for cmd 01, 3*LINE_NUM+1 for cmd 10, and cycle 1 for cmd 00.
REQ-024 The latched command SHALL govern the whole walk; cmd and cmd_valid changes while busy SHALL be ignored.
REQ-025 line_wb_done outside WB SHALL be ignored; line_wb_done in the same cycle line_wb first rises SHALL complete the writeback.
REQ-026 The requester SHALL drop cmd_valid at the edge where cmd_ready is high; the block accepts a new command no earlier than the cycle after DONE.
REQ-027 line_rd, line_wb and line_inv SHALL be mutually exclusive and low outside their states.

Reset
REQ-028 While rest=1, the state SHALL be IDLE, line_index=0, and cmd_ready, busy, line_rd, line_wb and line_inv SHALL all be 0, asynchronously.
REQ-029 Reset mid-operation SHALL abandon the walk, including any pending writeback, with no cmd_ready pulse.

Configuration
REQ-030 With macro CACHE_CMD_STAT_EN defined, SHALL add output wb_count[15:0]: lines written back by the current or last command.
REQ-031 wb_count SHALL clear on command accept, increment on each line_wb_done taken in WB, saturate at 16'hFFFF, and reset to 0.
REQ-032 Without CACHE_CMD_STAT_EN, the wb_count port and its logic SHALL be absent; other behaviour SHALL be identical.

Verification (LINE_NUM=4, INDEX_WIDTH=2)
REQ-033 cmd=01, all lines clean -> line_inv pulses at index 0,1,2,3; no line_wb; cmd_ready in cycle 17.
REQ-034 cmd=10, dirty at index 1 and 3, line_wb_done 3 cycles after line_wb rises -> line_wb only at index 1 and 3; no line_inv; wb_count=2.
REQ-035 cmd=11, dirty at index 2 -> line_wb then line_inv at index 2; line_inv at all four indices; cmd_ready once.
REQ-036 cmd=00 -> cmd_ready in cycle 1; no line_rd, line_wb or line_inv.
REQ-037 rest pulsed during WB at index 1 -> all outputs 0 immediately, no cmd_ready; the next cmd=01 restarts at index 0.
REQ-038 line_wb_done pulsed while IDLE, and cmd changed mid-walk -> no effect; the walk completes with the originally latched command.
